regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file: three combinational read ports and two synchronous write ports, with configurable data width and depth. It adds optional write-to-read bypass, an optional hard-wired zero register, and a defined write-port collision rule. A sequential clear sweep zeroes the whole array after reset or on request, replacing per-entry reset logic. It sits between decode (read addresses) and writeback (write ports) in the execution pipeline.

## Interface
- DATA_W, 16: width of each register in bits.
- ADDR_W, 6: address width; DEPTH = 2**ADDR_W entries.
- BYPASS, 0: when 1, a read of an address being written this cycle returns the write data.
- ZERO_R0, 0: when 1, entry 0 always reads 0 and writes to it are discarded.

- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous request to restart the clear sweep.
- busy  out  1  high while the clear sweep runs.
- reg_rd1, reg_rd2, reg_rd3  in  ADDR_W  read addresses.
- reg_rd1_out, reg_rd2_out, reg_rd3_out  out  DATA_W  read data.
- reg_wr1, reg_wr2  in  ADDR_W  write addresses.
- reg_wr1_data, reg_wr2_data  in  DATA_W  write data.
- reg_wr1_enable, reg_wr2_enable  in  1  write strobes.

## Operation
- States: CLEAR, RUN. `reset` low forces CLEAR, sweep counter = 0, busy = 1.
- CLEAR:
  - Each rising edge writes 0 to entry[counter], then increments the counter.
  - When the counter reaches DEPTH-1, that entry is cleared and the next state is RUN (busy = 0).
  - The sweep takes exactly DEPTH cycles after reset release.
- CLEAR behaviour for reads and writes:
  - Write strobes are ignored; writes are dropped, not queued.
  - All read outputs are 0.
- RUN:
  - On a rising edge, reg_wrN_enable = 1 writes reg_wrN_data to entry[reg_wrN].
  - Both ports enabled with the same address: port 2 wins and port 1's data is lost.
  - Both ports enabled with different addresses: both entries are written.
- `clear` = 1 in any state at a rising edge:
  - next state is CLEAR with counter = 0;
  - writes presented that cycle are dropped.
- Reads, RUN state:
  - reg_rdN_out = entry[reg_rdN], combinational.
  - ZERO_R0 = 1: address 0 reads 0.
- BYPASS = 1, RUN state, read address matches an enabled write address:
  - output is the write data (port 2 data if both ports match);
  - with ZERO_R0 = 1, address 0 is never bypassed.
- BYPASS = 0: a read returns the pre-edge value until the write edge.
- No arithmetic. All address values 0..DEPTH-1 are legal; there is no out-of-range case.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write-to-read latency: 1 edge (BYPASS = 0); 0 cycles (BYPASS = 1, combinational from write inputs).
- Reset values:
  - busy = 1.
  - All read outputs = 0.
  - Array contents are undefined until the sweep completes; they are never observable, because reads are forced to 0.
- busy falls on the DEPTH-th rising edge after `reset` goes high, or after the edge that sampled `clear`.
- `reset` asserted mid-sweep or mid-RUN takes effect immediately and asynchronously; the sweep restarts from 0 on release.
- `clear` held high keeps the counter at 0 and busy = 1.

## Test plan
- Reset release, ADDR_W = 6:
  - busy = 1 for exactly 64 edges, then 0;
  - all three read outputs are 0 throughout;
  - afterwards, reads of addresses 0, 17, 63 return 0.
- RUN, write port 1 addr 5 = 0x1234 and port 2 addr 9 = 0xBEEF on one edge:
  - next cycle rd1 = 5 gives 0x1234 and rd2 = 9 gives 0xBEEF;
  - with BYPASS = 0, the same-cycle read of 5 is still 0.
- Collision, both ports addr 12 (port 1 = 0x1111, port 2 = 0x2222):
  - rd3 = 12 returns 0x2222 after the edge;
  - with BYPASS = 1, it returns 0x2222 during the same cycle.
- ZERO_R0 = 1, write 0xFFFF to addr 0 -> rd1 = 0 returns 0 before and after the edge.
- Write 0xAAAA to addr 3, then pulse `clear`:
  - busy = 1 for 64 edges; addr 3 reads 0 throughout;
  - a write to addr 7 during the sweep is dropped, so addr 7 reads 0 after busy falls.
- Assert `reset` low 20 edges into the sweep -> busy stays 1 and outputs stay 0; after release, busy falls exactly 64 edges later.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file: three combinational reads, two synchronous writes,
// optional bypass and hard-wired zero entry, cleared by a sequential sweep.
module regfile_mp #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter bit BYPASS  = 1'b0,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    input  logic [ADDR_W-1:0] reg_rd1,
    input  logic [ADDR_W-1:0] reg_rd2,
    input  logic [ADDR_W-1:0] reg_rd3,
    output logic [DATA_W-1:0] reg_rd1_out,
    output logic [DATA_W-1:0] reg_rd2_out,
    output logic [DATA_W-1:0] reg_rd3_out,
    input  logic [ADDR_W-1:0] reg_wr1,
    input  logic [ADDR_W-1:0] reg_wr2,
    input  logic [DATA_W-1:0] reg_wr1_data,
    input  logic [DATA_W-1:0] reg_wr2_data,
    input  logic              reg_wr1_enable,
    input  logic              reg_wr2_enable
);
    // state | meaning
    // CLEAR | sweep writes 0 to entry[cnt_q]; writes dropped, reads forced to 0
    // RUN   | normal read/write operation
    typedef enum logic {CLEAR, RUN} state_t;

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               wr1_ok, wr2_ok;
    logic [ADDR_W-1:0]  rd_addr [3];
    logic [DATA_W-1:0]  rd_data [3];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign busy = (state_q == CLEAR);

    // Port 2 wins a same-address collision; entry 0 stays untouched when hard-wired.
    always_comb begin
        wr1_ok = reg_wr1_enable
                 && !(reg_wr2_enable && (reg_wr1 == reg_wr2))
                 && !(ZERO_R0 && (reg_wr1 == '0));
        wr2_ok = reg_wr2_enable && !(ZERO_R0 && (reg_wr2 == '0));
    end

    always_ff @(posedge clock) begin
        if (state_q == CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (!clear) begin
            if (wr1_ok) mem_q[reg_wr1] <= reg_wr1_data;
            if (wr2_ok) mem_q[reg_wr2] <= reg_wr2_data;
        end
    end

    always_comb begin
        rd_addr[0] = reg_rd1;
        rd_addr[1] = reg_rd2;
        rd_addr[2] = reg_rd3;
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = '0;
            if (state_q == RUN && !(ZERO_R0 && rd_addr[p] == '0)) begin
                if (BYPASS && reg_wr2_enable && rd_addr[p] == reg_wr2)
                    rd_data[p] = reg_wr2_data;
                else if (BYPASS && reg_wr1_enable && rd_addr[p] == reg_wr1)
                    rd_data[p] = reg_wr1_data;
                else
                    rd_data[p] = mem_q[rd_addr[p]];
            end
        end
    end

    assign reg_rd1_out = rd_data[0];
    assign reg_rd2_out = rd_data[1];
    assign reg_rd3_out = rd_data[2];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench driving two regfile_mp instances in lockstep:
// a plain one and one with bypass and hard-wired zero entry.
module tb_regfile_mp;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clear = 1'b0;
    logic [5:0]  rd1 = '0, rd2 = '0, rd3 = '0, wr1 = '0, wr2 = '0;
    logic [15:0] wd1 = '0, wd2 = '0;
    logic        we1 = 1'b0, we2 = 1'b0;

    logic        busy_a, busy_b;
    logic [15:0] a1, a2, a3, b1, b2, b3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    regfile_mp #(.DATA_W(16), .ADDR_W(6), .BYPASS(1'b0), .ZERO_R0(1'b0)) dut_a (
        .clock(clock), .reset(reset), .clear(clear), .busy(busy_a),
        .reg_rd1(rd1), .reg_rd2(rd2), .reg_rd3(rd3),
        .reg_rd1_out(a1), .reg_rd2_out(a2), .reg_rd3_out(a3),
        .reg_wr1(wr1), .reg_wr2(wr2), .reg_wr1_data(wd1), .reg_wr2_data(wd2),
        .reg_wr1_enable(we1), .reg_wr2_enable(we2)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(6), .BYPASS(1'b1), .ZERO_R0(1'b1)) dut_b (
        .clock(clock), .reset(reset), .clear(clear), .busy(busy_b),
        .reg_rd1(rd1), .reg_rd2(rd2), .reg_rd3(rd3),
        .reg_rd1_out(b1), .reg_rd2_out(b2), .reg_rd3_out(b3),
        .reg_wr1(wr1), .reg_wr2(wr2), .reg_wr1_data(wd1), .reg_wr2_data(wd2),
        .reg_wr1_enable(we1), .reg_wr2_enable(we2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, " a1"}, a1, 16'h0); chk({tag, " a2"}, a2, 16'h0); chk({tag, " a3"}, a3, 16'h0);
        chk({tag, " b1"}, b1, 16'h0); chk({tag, " b2"}, b2, 16'h0); chk({tag, " b3"}, b3, 16'h0);
    endtask

    // Counts edges from now on; busy must stay high until the 64th edge.
    task automatic sweep(input string tag, input bool_write7);
        for (int i = 1; i <= 64; i++) begin
            if (bool_write7 && i == 10) begin
                wr1 = 6'd7; wd1 = 16'h7777; we1 = 1'b1;
            end
            step();
            we1 = 1'b0;
            chk({tag, " busy_a"}, {15'd0, busy_a}, {15'd0, (i < 64)});
            chk({tag, " busy_b"}, {15'd0, busy_b}, {15'd0, (i < 64)});
            if (i < 64) chk_zero_outs({tag, " outs"});
        end
    endtask

    initial begin
        rd1 = 6'd3; rd2 = 6'd17; rd3 = 6'd63;
        #3;
        chk("rst busy_a", {15'd0, busy_a}, 16'd1);
        chk("rst busy_b", {15'd0, busy_b}, 16'd1);
        chk_zero_outs("rst");
        step(); step();
        chk("rst hold busy_a", {15'd0, busy_a}, 16'd1);

        reset = 1'b1;
        sweep("sweep1", 1'b0);
        rd1 = 6'd0; rd2 = 6'd17; rd3 = 6'd63;
        #1;
        chk_zero_outs("post sweep");

        // Dual write, different addresses
        rd1 = 6'd5; rd2 = 6'd9;
        wr1 = 6'd5; wd1 = 16'h1234; we1 = 1'b1;
        wr2 = 6'd9; wd2 = 16'hBEEF; we2 = 1'b1;
        #1;
        chk("wr same-cycle a1", a1, 16'h0000);
        chk("wr same-cycle a2", a2, 16'h0000);
        chk("wr bypass b1", b1, 16'h1234);
        chk("wr bypass b2", b2, 16'hBEEF);
        step();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        chk("wr after a1", a1, 16'h1234);
        chk("wr after a2", a2, 16'hBEEF);
        chk("wr after b1", b1, 16'h1234);
        chk("wr after b2", b2, 16'hBEEF);

        // Collision on address 12
        rd3 = 6'd12;
        wr1 = 6'd12; wd1 = 16'h1111; we1 = 1'b1;
        wr2 = 6'd12; wd2 = 16'h2222; we2 = 1'b1;
        #1;
        chk("coll same-cycle a3", a3, 16'h0000);
        chk("coll bypass b3", b3, 16'h2222);
        step();
        we1 = 1'b0; we2 = 1'b0;
        #1;
        chk("coll after a3", a3, 16'h2222);
        chk("coll after b3", b3, 16'h2222);
        chk("coll keeps a1", a1, 16'h1234);

        // Write to address 0
        rd1 = 6'd0;
        wr1 = 6'd0; wd1 = 16'hFFFF; we1 = 1'b1;
        #1;
        chk("r0 before a1", a1, 16'h0000);
        chk("r0 before b1", b1, 16'h0000);
        step();
        we1 = 1'b0;
        #1;
        chk("r0 after a1", a1, 16'hFFFF);
        chk("r0 after b1", b1, 16'h0000);

        // Clear pulse, write to 7 during the sweep must be dropped
        wr1 = 6'd3; wd1 = 16'hAAAA; we1 = 1'b1;
        step();
        we1 = 1'b0;
        rd1 = 6'd3;
        #1;
        chk("pre clear a1", a1, 16'hAAAA);
        chk("pre clear b1", b1, 16'hAAAA);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear busy_a", {15'd0, busy_a}, 16'd1);
        chk_zero_outs("clear edge");
        sweep("sweep2", 1'b1);
        rd1 = 6'd3; rd2 = 6'd7; rd3 = 6'd9;
        #1;
        chk_zero_outs("post clear");

        // Reset asserted 20 edges into a sweep
        wr2 = 6'd20; wd2 = 16'h5A5A; we2 = 1'b1;
        step();
        we2 = 1'b0;
        rd1 = 6'd20;
        #1;
        chk("pre reset a1", a1, 16'h5A5A);
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("mid sweep busy_a", {15'd0, busy_a}, 16'd1);
        reset = 1'b0;
        #1;
        chk("in reset busy_a", {15'd0, busy_a}, 16'd1);
        chk("in reset busy_b", {15'd0, busy_b}, 16'd1);
        chk_zero_outs("in reset");
        step(); step(); step();
        chk("reset held busy_b", {15'd0, busy_b}, 16'd1);
        reset = 1'b1;
        sweep("sweep3", 1'b0);
        chk("post reset sweep a1", a1, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
